// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// opcode/funct constants, ALU control codes, PC/ALU-B mux selects and the
// bundled control-word type driven by the FSM output logic.
package mc_control_fsm_pkg;

  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, ALUWB, BRANCH,
    ADDIEXEC, ADDIWB, JUMP, JAL, JR, MFWB, MULT, MULTWAIT
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type functs (IR[5:0])
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BTA  = 2'b11;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       jalsel;
    logic       select_result;
    logic       hi_lo;
    logic       hi_lo_load;
    logic       mult_start;
    logic       illegal;
    logic       mult_timeout;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the FSM and the datapath.
//   master: FSM side   (inputs op/funct/zero/mult_done, drives control outputs)
//   slave : datapath side (mirror image)
interface mc_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mult_done;

  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       jalsel;
  logic       select_result;
  logic       hi_lo;
  logic       hi_lo_load;
  logic       mult_start;
  logic       illegal;
  logic       mult_timeout;

  modport master (
    input  op, funct, zero, mult_done,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, jalsel, select_result,
           hi_lo, hi_lo_load, mult_start, illegal, mult_timeout
  );

  modport slave (
    output op, funct, zero, mult_done,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, jalsel, select_result,
           hi_lo, hi_lo_load, mult_start, illegal, mult_timeout
  );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// alu_decoder: maps an R-type funct to the ALU control code.
//   funct_i      : instruction funct field
//   alucontrol_o : ALU operation for R arithmetic functs (ADD otherwise)
//   arith_o      : funct is one of add/sub/and/or/slt
module alu_decoder (
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       arith_o
);
  import mc_control_fsm_pkg::*;

  always_comb begin
    alucontrol_o = ALU_ADD;
    arith_o      = 1'b1;
    case (funct_i)
      FN_ADD:  alucontrol_o = ALU_ADD;
      FN_SUB:  alucontrol_o = ALU_SUB;
      FN_AND:  alucontrol_o = ALU_AND;
      FN_OR:   alucontrol_o = ALU_OR;
      FN_SLT:  alucontrol_o = ALU_SLT;
      default: arith_o      = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with multiplier wait/timeout handling.
//   clk, reset : clock, synchronous active-high reset
//   bus        : control interface (master side), see mc_control_fsm_if
//   MULT_WAIT_MAX : maximum MULTWAIT cycles before mult_timeout (1..128)
module mc_control_fsm #(
  parameter int unsigned MULT_WAIT_MAX = 64
) (
  input logic              clk,
  input logic              reset,
  mc_control_fsm_if.master bus
);
  import mc_control_fsm_pkg::*;

  localparam logic [6:0] WAIT_LAST = 7'(MULT_WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [6:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] funct_alu;
  logic       funct_arith;
  logic       wait_expired;
  ctrl_t      ctrl;

  alu_decoder u_alu_decoder (
    .funct_i      (bus.funct),
    .alucontrol_o (funct_alu),
    .arith_o      (funct_arith)
  );

  // wait_cnt_q holds the number of MULTWAIT cycles already completed
  assign wait_expired = (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          OP_JAL:       state_d = JAL;
          OP_RTYPE: begin
            if (funct_arith) begin
              state_d = RTEXEC;
            end else begin
              case (bus.funct)
                FN_MULTU:         state_d = MULT;
                FN_MFHI, FN_MFLO: state_d = MFWB;
                FN_JR:            state_d = JR;
                default:          state_d = FETCH;
              endcase
            end
          end
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      RTEXEC:   state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      MULT: begin
        state_d    = MULTWAIT;
        wait_cnt_d = '0;
      end
      MULTWAIT: begin
        if (bus.mult_done || wait_expired) begin
          state_d = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 7'd1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          ctrl.irwrite    = 1'b1;
          ctrl.pcen       = 1'b1;
          ctrl.alusrcb    = SRCB_FOUR;
          ctrl.alucontrol = ALU_ADD;
          ctrl.pcsrc      = PCSRC_PLUS4;
        end
        DECODE: begin
          ctrl.alusrcb    = SRCB_BTA;
          ctrl.alucontrol = ALU_ADD;
          // DECODE falls back to FETCH only for unsupported op/funct
          ctrl.illegal    = (state_d == FETCH);
        end
        MEMADR, ADDIEXEC: begin
          ctrl.alusrca    = 1'b1;
          ctrl.alusrcb    = SRCB_IMM;
          ctrl.alucontrol = ALU_ADD;
        end
        MEMRD: ctrl.iord = 1'b1;
        MEMWB: begin
          ctrl.regwrite = 1'b1;
          ctrl.memtoreg = 1'b1;
        end
        MEMWR: begin
          ctrl.iord     = 1'b1;
          ctrl.memwrite = 1'b1;
        end
        RTEXEC: begin
          ctrl.alusrca    = 1'b1;
          ctrl.alusrcb    = SRCB_REG;
          ctrl.alucontrol = funct_alu;
        end
        ALUWB: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
        end
        BRANCH: begin
          ctrl.alusrca    = 1'b1;
          ctrl.alucontrol = ALU_SUB;
          ctrl.pcsrc      = PCSRC_BRANCH;
          ctrl.pcen       = bus.zero;
        end
        ADDIWB: ctrl.regwrite = 1'b1;
        JUMP: begin
          ctrl.pcen  = 1'b1;
          ctrl.pcsrc = PCSRC_JUMP;
        end
        JAL: begin
          ctrl.pcen     = 1'b1;
          ctrl.pcsrc    = PCSRC_JUMP;
          ctrl.regwrite = 1'b1;
          ctrl.jalsel   = 1'b1;
        end
        JR: begin
          ctrl.pcen  = 1'b1;
          ctrl.pcsrc = PCSRC_REG;
        end
        MFWB: begin
          ctrl.regwrite      = 1'b1;
          ctrl.regdst        = 1'b1;
          ctrl.select_result = 1'b1;
          ctrl.hi_lo         = (bus.funct == FN_MFHI);
        end
        MULT: ctrl.mult_start = 1'b1;
        MULTWAIT: begin
          ctrl.hi_lo_load   = bus.mult_done;
          ctrl.mult_timeout = !bus.mult_done && wait_expired;
        end
        default: ;
      endcase
    end
  end

  assign bus.pcen          = ctrl.pcen;
  assign bus.iord          = ctrl.iord;
  assign bus.memwrite      = ctrl.memwrite;
  assign bus.irwrite       = ctrl.irwrite;
  assign bus.regdst        = ctrl.regdst;
  assign bus.memtoreg      = ctrl.memtoreg;
  assign bus.regwrite      = ctrl.regwrite;
  assign bus.alusrca       = ctrl.alusrca;
  assign bus.alusrcb       = ctrl.alusrcb;
  assign bus.pcsrc         = ctrl.pcsrc;
  assign bus.alucontrol    = ctrl.alucontrol;
  assign bus.jalsel        = ctrl.jalsel;
  assign bus.select_result = ctrl.select_result;
  assign bus.hi_lo         = ctrl.hi_lo;
  assign bus.hi_lo_load    = ctrl.hi_lo_load;
  assign bus.mult_start    = ctrl.mult_start;
  assign bus.illegal       = ctrl.illegal;
  assign bus.mult_timeout  = ctrl.mult_timeout;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: per-instruction cycle-by-cycle expected
// control words built from the instruction-class rules, random instruction
// streams with stray mult_done pulses, and reset in mid-instruction.
module tb_mc_control_fsm;

  localparam int unsigned WAIT_MAX = 64;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_JAL   = 6'b000011;
  localparam logic [5:0] T_MULTU = 6'b011001;
  localparam logic [5:0] T_MFHI  = 6'b010000;
  localparam logic [5:0] T_MFLO  = 6'b010010;
  localparam logic [5:0] T_JR    = 6'b001000;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       jalsel, select_result, hi_lo, hi_lo_load, mult_start, illegal, mult_timeout;
  } exp_t;

  typedef enum {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_JAL, K_JR, K_MF, K_MULT, K_ILL} kind_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.MULT_WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t        exp_q[$];
  bit          dn_q[$];
  exp_t        obs_q[$];

  function automatic exp_t sample();
    exp_t s;
    s.pcen = bus.pcen;         s.iord = bus.iord;         s.memwrite = bus.memwrite;
    s.irwrite = bus.irwrite;   s.regdst = bus.regdst;     s.memtoreg = bus.memtoreg;
    s.regwrite = bus.regwrite; s.alusrca = bus.alusrca;   s.alusrcb = bus.alusrcb;
    s.pcsrc = bus.pcsrc;       s.alucontrol = bus.alucontrol;
    s.jalsel = bus.jalsel;     s.select_result = bus.select_result;
    s.hi_lo = bus.hi_lo;       s.hi_lo_load = bus.hi_lo_load;
    s.mult_start = bus.mult_start; s.illegal = bus.illegal;
    s.mult_timeout = bus.mult_timeout;
    return s;
  endfunction

  function automatic kind_t classify(logic [5:0] op, logic [5:0] fn);
    kind_t k;
    k = K_ILL;
    case (op)
      T_LW:   k = K_LW;
      T_SW:   k = K_SW;
      T_BEQ:  k = K_BEQ;
      T_ADDI: k = K_ADDI;
      T_J:    k = K_J;
      T_JAL:  k = K_JAL;
      T_RTYPE: begin
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: k = K_R;
          T_MULTU:        k = K_MULT;
          T_MFHI, T_MFLO: k = K_MF;
          T_JR:           k = K_JR;
          default:        k = K_ILL;
        endcase
      end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [2:0] alu_for(logic [5:0] fn);
    logic [2:0] a;
    case (fn)
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      default:   a = 3'b010;
    endcase
    return a;
  endfunction

  function automatic void push(exp_t c, bit d);
    exp_q.push_back(c);
    dn_q.push_back(d);
  endfunction

  function automatic bit stray();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control word per cycle, plus the mult_done value driven in
  // that cycle (random outside MULTWAIT, where it must be ignored).
  // dly = MULTWAIT cycle (1-based) carrying mult_done; 0 = never.
  function automatic void build(logic [5:0] op, logic [5:0] fn, logic z, int unsigned dly);
    exp_t  c;
    kind_t k;
    bit    ended;
    exp_q.delete();
    dn_q.delete();
    k = classify(op, fn);
    c = '0; c.irwrite = 1; c.pcen = 1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
    push(c, stray());
    c = '0; c.alusrcb = 2'b11; c.alucontrol = 3'b010; c.illegal = (k == K_ILL);
    push(c, stray());
    if (k == K_LW || k == K_SW || k == K_ADDI) begin
      c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
      push(c, stray());
    end
    case (k)
      K_LW: begin
        c = '0; c.iord = 1; push(c, stray());
        c = '0; c.regwrite = 1; c.memtoreg = 1; push(c, stray());
      end
      K_SW:   begin c = '0; c.iord = 1; c.memwrite = 1; push(c, stray()); end
      K_ADDI: begin c = '0; c.regwrite = 1; push(c, stray()); end
      K_R: begin
        c = '0; c.alusrca = 1; c.alucontrol = alu_for(fn); push(c, stray());
        c = '0; c.regwrite = 1; c.regdst = 1; push(c, stray());
      end
      K_BEQ: begin
        c = '0; c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
        push(c, stray());
      end
      K_J:   begin c = '0; c.pcen = 1; c.pcsrc = 2'b10; push(c, stray()); end
      K_JAL: begin
        c = '0; c.pcen = 1; c.pcsrc = 2'b10; c.regwrite = 1; c.jalsel = 1;
        push(c, stray());
      end
      K_JR:  begin c = '0; c.pcen = 1; c.pcsrc = 2'b11; push(c, stray()); end
      K_MF: begin
        c = '0; c.regwrite = 1; c.regdst = 1; c.select_result = 1; c.hi_lo = (fn == T_MFHI);
        push(c, stray());
      end
      K_MULT: begin
        c = '0; c.mult_start = 1; push(c, stray());
        ended = 0;
        for (int unsigned i = 1; i <= WAIT_MAX && !ended; i++) begin
          c = '0;
          if (dly == i) begin
            c.hi_lo_load = 1; push(c, 1'b1); ended = 1;
          end else if (i == WAIT_MAX) begin
            c.mult_timeout = 1; push(c, 1'b0); ended = 1;
          end else begin
            push(c, 1'b0);
          end
        end
      end
      default: ;
    endcase
  endfunction

  // Entered and left at posedge+1 of a cycle in which the DUT shows FETCH.
  // ncyc != 0 stops after that many cycles.
  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int unsigned dly, input int unsigned ncyc);
    build(op, fn, z, dly);
    if (ncyc != 0)
      while (exp_q.size() > int'(ncyc)) begin
        void'(exp_q.pop_back());
        void'(dn_q.pop_back());
      end
    obs_q.delete();
    bus.op = op; bus.funct = fn; bus.zero = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mult_done = dn_q[i];
      @(negedge clk);
      obs_q.push_back(sample());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    exp_t got;
    reset = 1'b1;
    bus.op = 6'($urandom); bus.funct = 6'($urandom); bus.zero = 1'b1; bus.mult_done = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = sample();
      tests++;
      if (got !== '0) begin
        fails++;
        $display("FAIL reset_outputs cyc %0d got=%h exp=0", i, got);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_addi();
    drive_instr(T_ADDI, 6'($urandom), 1'b0, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL addi cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      drive_instr(T_BEQ, 6'($urandom), 1'(z), 0, 0);
      foreach (obs_q[i]) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL beq_zero%0d cyc %0d got=%h exp=%h", z, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_multu();
    int unsigned dlys[3] = '{5, 1, WAIT_MAX};
    foreach (dlys[d]) begin
      drive_instr(T_RTYPE, T_MULTU, 1'b0, dlys[d], 0);
      foreach (obs_q[i]) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL multu_done%0d cyc %0d got=%h exp=%h", dlys[d], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mult_timeout();
    drive_instr(T_RTYPE, T_MULTU, 1'b0, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL mult_timeout cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    drive_instr(6'b111111, 6'($urandom), 1'b1, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL illegal_op cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    drive_instr(T_RTYPE, 6'b111111, 1'b1, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL illegal_funct cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // Runs ncyc cycles of an instruction, then a one-cycle reset; the next
  // instruction's sequence (starting at FETCH) is checked in full.
  task automatic test_reset_mid(input string name, input logic [5:0] op, input logic [5:0] fn,
                                input int unsigned ncyc);
    exp_t got;
    drive_instr(op, fn, 1'b0, 0, ncyc);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s_pre cyc %0d got=%h exp=%h", name, i, obs_q[i], exp_q[i]);
      end
    end
    reset = 1'b1;
    bus.mult_done = 1'b1;
    @(negedge clk);
    got = sample();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL %s_during_reset got=%h exp=0", name, got);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive_instr(T_RTYPE, 6'b100100, 1'b0, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s_after_reset cyc %0d got=%h exp=%h", name, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[10] = '{T_RTYPE, T_RTYPE, T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J, T_JAL, 6'b000000};
    logic [5:0] fns[10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            T_MULTU, T_MFHI, T_MFLO, T_JR, 6'b000000};
    logic [5:0] op, fn;
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      drive_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(1, 12), 0);
      foreach (obs_q[i]) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL rand%0d op=%b fn=%b cyc %0d got=%h exp=%h",
                   n, op, fn, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mult_done = 1'b0;
    test_reset();
    test_addi();
    test_branch();
    test_multu();
    test_mult_timeout();
    test_illegal();
    test_reset_mid("reset_memrd", T_LW, 6'b000000, 3);
    test_reset_mid("reset_multwait", T_RTYPE, T_MULTU, 23);
    test_mult_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
